mem_arbiter: RTL and testbench

- Shares the single byte-wide 1024x8 synchronous RAM between two 32-bit requesters: port A (instruction fetch, read-only) and port B (data, read/write).
- Serialises each 32-bit access into four little-endian byte beats.
- Arbitrates simultaneous requests round-robin.
- Captures port-B writes to the magic address into a register for the testbench.
- Sits between the y86 core's fetch/data paths and the RAM macro.

---
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a byte-wide synchronous RAM between a 32-bit fetch port (A)
// and a 32-bit data port (B); each word access becomes four little-endian byte beats.
module mem_arbiter #(
  parameter int          ADDR_W     = 10,
  parameter logic [31:0] MAGIC_ADDR = 32'hFFFF_FFF0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic [31:0]       a_addr,
  output logic              a_ack,
  output logic [31:0]       a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [31:0]       b_addr,
  input  logic [31:0]       b_wdata,
  output logic              b_ack,
  output logic [31:0]       b_rdata,
  output logic              mem_ena,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  output logic [31:0]       magic_out,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, BEAT, CAPTURE, DONE} state_t;

  state_t      state;
  logic        ptr_b;
  logic        sel_b;
  logic        we_q;
  logic [1:0]  beat;
  logic [23:0] wdata_q;
  logic [23:0] rbytes;

  logic        grant_any;
  logic        grant_b;
  logic        grant_we;
  logic        grant_magic;
  logic [31:0] grant_addr;

  always_comb begin
    grant_any   = a_req | b_req;
    grant_b     = b_req & (~a_req | ptr_b);
    grant_we    = grant_b & b_we;
    grant_addr  = grant_b ? b_addr : a_addr;
    grant_magic = grant_we && (b_addr == MAGIC_ADDR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr_b     <= 1'b0;
      sel_b     <= 1'b0;
      we_q      <= 1'b0;
      beat      <= '0;
      wdata_q   <= '0;
      rbytes    <= '0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      mem_ena   <= 1'b0;
      mem_wea   <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      magic_out <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            sel_b   <= grant_b;
            ptr_b   <= ~grant_b;
            we_q    <= grant_we;
            wdata_q <= b_wdata[31:8];
            busy    <= 1'b1;
            if (grant_magic) begin
              magic_out <= b_wdata;
              b_ack     <= 1'b1;
              state     <= DONE;
            end else begin
              beat     <= '0;
              mem_ena  <= 1'b1;
              mem_wea  <= grant_we;
              mem_addr <= grant_addr[ADDR_W-1:0];
              mem_din  <= grant_we ? b_wdata[7:0] : '0;
              state    <= BEAT;
            end
          end
        end
        BEAT: begin
          // Read data lags its beat by one cycle; bytes 0..2 shift in from the top.
          if (beat != 2'd0)
            rbytes <= {mem_dout, rbytes[23:8]};
          if (beat == 2'd3) begin
            mem_ena <= 1'b0;
            mem_wea <= 1'b0;
            if (we_q) begin
              a_ack <= ~sel_b;
              b_ack <= sel_b;
              state <= DONE;
            end else begin
              state <= CAPTURE;
            end
          end else begin
            beat     <= beat + 2'd1;
            mem_addr <= mem_addr + 1'b1;
            mem_din  <= we_q ? wdata_q[7:0] : '0;
            wdata_q  <= {8'h00, wdata_q[23:8]};
          end
        end
        CAPTURE: begin
          if (sel_b) begin
            b_rdata <= {mem_dout, rbytes};
            b_ack   <= 1'b1;
          end else begin
            a_rdata <= {mem_dout, rbytes};
            a_ack   <= 1'b1;
          end
          state <= DONE;
        end
        DONE: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM, word-level reference model, directed and
// randomized transactions checked for data, beat addresses, latency and grant order.
module tb_mem_arbiter;

  localparam int          AW    = 10;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] MAGIC = 32'hFFFF_FFF0;

  logic          clk;
  logic          rst;
  logic          a_req, b_req, b_we;
  logic [31:0]   a_addr, b_addr, b_wdata;
  logic          a_ack, b_ack, mem_ena, mem_wea, busy;
  logic [31:0]   a_rdata, b_rdata, magic_out;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din, mem_dout;

  logic [7:0]    ram [DEPTH];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [7:0]    bd_data;

  logic [7:0]    ref_mem [DEPTH];
  logic [31:0]   ref_magic, exp_a_rdata, exp_b_rdata;

  int unsigned   n_checks = 0;
  int unsigned   n_fails  = 0;

  mem_arbiter #(.ADDR_W(AW), .MAGIC_ADDR(MAGIC)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .magic_out(magic_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous read-first RAM with a backdoor port used only for preloading.
  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_ena) begin
      if (mem_wea) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] addr);
    logic [31:0] w;
    w = '0;
    for (int unsigned k = 0; k < 4; k++)
      w[8*k +: 8] = ref_mem[(addr + k) % DEPTH];
    return w;
  endfunction

  task automatic ref_write(input logic [31:0] addr, input logic [31:0] d);
    if (addr == MAGIC) ref_magic = d;
    else for (int unsigned k = 0; k < 4; k++) ref_mem[(addr + k) % DEPTH] = d[8*k +: 8];
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, 32'({mem_ena, mem_wea, a_ack, b_ack, busy}), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_mem_din"}, 32'(mem_din), 0);
    check({tag, "_a_rdata"}, a_rdata, 0);
    check({tag, "_b_rdata"}, b_rdata, 0);
    check({tag, "_magic"}, magic_out, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    exp_a_rdata = '0; exp_b_rdata = '0; ref_magic = '0;
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!busy) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen) check("idle_timeout", 32'(busy), 0);
  endtask

  // Issues one request in an IDLE cycle (cycle 0) and follows it to its ack.
  task automatic run_txn(input bit pb, input bit we_in, input logic [31:0] addr,
                         input logic [31:0] wd);
    bit          we, magic;
    int unsigned lat, nb, got_c;
    we    = pb & we_in;
    magic = pb && we && (addr == MAGIC);
    lat   = magic ? 1 : (we ? 5 : 6);
    wait_idle();
    if (pb) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
    else    begin a_req = 1'b1; a_addr = addr; end
    nb = 0; got_c = 0;
    for (int unsigned c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_ena) begin
        check("beat_cycle", c, nb + 1);
        check("beat_addr", 32'(mem_addr), (addr + nb) % DEPTH);
        check("beat_we", 32'(mem_wea), 32'(we));
        if (we) check("beat_din", 32'(mem_din), (wd >> (8*nb)) & 32'hFF);
        nb++;
      end
      check("stray_ack", 32'(pb ? a_ack : b_ack), 0);
      if (pb ? b_ack : a_ack) begin got_c = c; break; end
    end
    check("ack_cycle", got_c, lat);
    check("beat_count", nb, magic ? 0 : 4);
    if (we) ref_write(addr, wd);
    else if (pb) exp_b_rdata = ref_read(addr);
    else exp_a_rdata = ref_read(addr);
    check("a_rdata", a_rdata, exp_a_rdata);
    check("b_rdata", b_rdata, exp_b_rdata);
    check("magic_out", magic_out, ref_magic);
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    check("ack_pulse", 32'({a_ack, b_ack}), 0);
    check("busy_idle", 32'(busy), 0);
  endtask

  // Both ports request together after reset and re-request after each ack.
  task automatic contention();
    int unsigned a_left, b_left, idx;
    logic [31:0] a_cur, b_cur, b_wd;
    bit          b_cur_we;
    do_reset();
    a_left = 3; b_left = 3; idx = 0;
    a_cur = $urandom; b_cur = $urandom_range(0, 1023);
    b_cur_we = 1'($urandom_range(0, 1)); b_wd = $urandom;
    a_req = 1'b1; a_addr = a_cur;
    b_req = 1'b1; b_we = b_cur_we; b_addr = b_cur; b_wdata = b_wd;
    for (int c = 0; c < 120 && (a_left != 0 || b_left != 0); c++) begin
      @(negedge clk);
      if (a_ack) begin
        check("rr_order_a", idx % 2, 0);
        exp_a_rdata = ref_read(a_cur);
        check("rr_a_rdata", a_rdata, exp_a_rdata);
        idx++; a_left--;
        if (a_left != 0) begin a_cur = $urandom; a_addr = a_cur; end
        else a_req = 1'b0;
      end
      if (b_ack) begin
        check("rr_order_b", idx % 2, 1);
        if (b_cur_we) ref_write(b_cur, b_wd);
        else begin
          exp_b_rdata = ref_read(b_cur);
          check("rr_b_rdata", b_rdata, exp_b_rdata);
        end
        idx++; b_left--;
        if (b_left != 0) begin
          b_cur = $urandom_range(0, 1023); b_cur_we = 1'($urandom_range(0, 1)); b_wd = $urandom;
          b_addr = b_cur; b_we = b_cur_we; b_wdata = b_wd;
        end else b_req = 1'b0;
      end
    end
    check("rr_grants", idx, 6);
    a_req = 1'b0; b_req = 1'b0;
    check("rr_magic", magic_out, ref_magic);
  endtask

  task automatic reset_mid_write();
    logic [31:0] wd;
    wd = $urandom;
    wait_idle();
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'd16; b_wdata = wd;
    repeat (3) @(negedge clk);
    check("rstw_beat2_addr", 32'(mem_addr), 18);
    rst = 1'b0;
    #1;
    check_reset_outputs("rstw");
    b_req = 1'b0;
    ref_mem[16] = wd[7:0];
    ref_mem[17] = wd[15:8];
    exp_a_rdata = '0; exp_b_rdata = '0; ref_magic = '0;
    @(negedge clk);
    @(negedge clk);
    check("rstw_no_ack", 32'(b_ack), 0);
    for (int unsigned k = 16; k < 20; k++) check("rstw_ram", 32'(ram[k]), 32'(ref_mem[k]));
    rst = 1'b1;
    run_txn(1'b0, 1'b0, 32'd16, 32'd0);
  endtask

  initial begin
    logic [7:0] v;
    clk = 1'b0; rst = 1'b0;
    a_req = 1'b0; a_addr = '0; b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    ref_magic = '0; exp_a_rdata = '0; exp_b_rdata = '0;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      case (i)
        0: v = 8'h29; 1: v = 8'hF6; 2: v = 8'h29; 3: v = 8'hC0;
        default: v = 8'($urandom);
      endcase
      bd_we = 1'b1; bd_addr = AW'(i); bd_data = v; ref_mem[i] = v;
    end
    @(negedge clk);
    bd_we = 1'b0;
    check_reset_outputs("por");
    rst = 1'b1;
    @(negedge clk);

    run_txn(1'b0, 1'b0, 32'd0, 32'd0);
    check("t1_word", a_rdata, 32'hC029_F629);

    run_txn(1'b1, 1'b1, 32'd8, 32'hDEAD_BEEF);
    check("t2_ram", {ram[11], ram[10], ram[9], ram[8]}, 32'hDEAD_BEEF);
    run_txn(1'b1, 1'b0, 32'd8, 32'd0);
    check("t2_word", b_rdata, 32'hDEAD_BEEF);

    contention();

    run_txn(1'b1, 1'b1, MAGIC, 32'h0000_002A);
    check("t4_magic", magic_out, 32'h0000_002A);

    run_txn(1'b1, 1'b1, 32'd1022, 32'h1122_3344);
    check("t5_wrap", {ram[1], ram[0], ram[1023], ram[1022]}, 32'h1122_3344);

    reset_mid_write();

    for (int n = 0; n < 40; n++) begin
      logic [31:0] addr;
      int unsigned sel;
      sel = $urandom_range(0, 5);
      if (sel == 0)      addr = MAGIC;
      else if (sel == 1) addr = 32'(1020 + $urandom_range(0, 3));
      else               addr = $urandom;
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
